// File: rtl/offset_add_cmp_pipe_if.sv
// Valid/ready bus for offset_add_cmp_pipe: input beat (offset, operands, thresholds,
// mode) and result beat (sum, gt, ovf). master = producer/consumer side, slave = DUT.
interface offset_add_cmp_pipe_if #(
  parameter int unsigned NCH = 3,
  parameter int unsigned DW  = 3,
  parameter int unsigned OW  = 2,
  parameter int unsigned AW  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [OW-1:0]     offset;
  logic [NCH*DW-1:0] a;
  logic [NCH*AW-1:0] thr;
  logic              mode_acc;
  logic              clr;
  logic              out_valid;
  logic              out_ready;
  logic [NCH*AW-1:0] sum;
  logic [NCH-1:0]    gt;
  logic [NCH-1:0]    ovf;

  modport master (
    output in_valid, offset, a, thr, mode_acc, clr, out_ready,
    input  in_ready, out_valid, sum, gt, ovf
  );

  modport slave (
    input  in_valid, offset, a, thr, mode_acc, clr, out_ready,
    output in_ready, out_valid, sum, gt, ovf
  );
endinterface

// File: rtl/offset_add_cmp_pipe.sv
// NCH-channel two-stage add (shared offset, optional accumulation) + threshold compare.
// Define ADDCMP_SAT_EN to saturate sums at 2^AW-1 instead of wrapping.
module offset_add_cmp_pipe #(
  parameter int unsigned NCH = 3,
  parameter int unsigned DW  = 3,
  parameter int unsigned OW  = 2,
  parameter int unsigned AW  = 5
) (
  input logic                   clk,
  input logic                   rst_n,
  offset_add_cmp_pipe_if.slave  io_bus
);
  localparam int unsigned TW = AW + 1;
  localparam logic [AW-1:0] MAXV = '1;

  logic              w_adv1;
  logic              w_adv2;
  logic              w_accept;
  logic [TW-1:0]     w_t   [NCH];
  logic [AW-1:0]     w_r   [NCH];
  logic [NCH-1:0]    w_ovf1;

  logic              r_s1_valid;
  logic [AW-1:0]     r_s1_sum [NCH];
  logic [AW-1:0]     r_s1_thr [NCH];
  logic [NCH-1:0]    r_s1_ovf;
  logic [AW-1:0]     r_acc    [NCH];

  logic              r_out_valid;
  logic [NCH*AW-1:0] r_sum;
  logic [NCH-1:0]    r_gt;
  logic [NCH-1:0]    r_ovf;

  // Pipeline advance: a stage moves when it is empty or its successor moves.
  assign w_adv2          = !r_out_valid || io_bus.out_ready;
  assign w_adv1          = !r_s1_valid || w_adv2;
  assign w_accept        = io_bus.in_valid && w_adv1;
  assign io_bus.in_ready = w_adv1;

  assign io_bus.out_valid = r_out_valid;
  assign io_bus.sum       = r_sum;
  assign io_bus.gt        = r_gt;
  assign io_bus.ovf       = r_ovf;

  // Stage-1 sum at AW+1 bits; clr forces a fresh accumulation base of zero.
  always_comb begin : stage1_math
    for (int unsigned k = 0; k < NCH; k++) begin
      w_t[k]    = ((io_bus.mode_acc && !io_bus.clr) ? TW'(r_acc[k]) : TW'(0))
                + TW'(io_bus.a[k*DW +: DW])
                + TW'(io_bus.offset);
      w_ovf1[k] = w_t[k][AW];
`ifdef ADDCMP_SAT_EN
      w_r[k]    = w_ovf1[k] ? MAXV : w_t[k][AW-1:0];
`else
      w_r[k]    = w_t[k][AW-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : stage1_regs
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_ovf   <= '0;
      for (int unsigned k = 0; k < NCH; k++) begin
        r_s1_sum[k] <= '0;
        r_s1_thr[k] <= '0;
        r_acc[k]    <= '0;
      end
    end else begin
      if (w_adv1) begin
        r_s1_valid <= io_bus.in_valid;
      end
      for (int unsigned k = 0; k < NCH; k++) begin
        if (w_accept) begin
          r_s1_sum[k] <= w_r[k];
          r_s1_thr[k] <= io_bus.thr[k*AW +: AW];
          r_s1_ovf[k] <= w_ovf1[k];
        end
        if (w_accept && io_bus.mode_acc) begin
          r_acc[k] <= w_r[k];
        end else if (io_bus.clr) begin
          r_acc[k] <= '0;
        end
      end
    end
  end

  // Stage 2 holds everything while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin : stage2_regs
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_gt        <= '0;
      r_ovf       <= '0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      for (int unsigned k = 0; k < NCH; k++) begin
        r_sum[k*AW +: AW] <= r_s1_sum[k];
        r_ovf[k]          <= r_s1_ovf[k];
        r_gt[k]           <= (r_s1_thr[k] > r_s1_sum[k]);
      end
    end
  end
endmodule
